// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
//
// Iterative AES encryption controller. It owns one shared round datapath (an
// external `round` instance and a `final_round` instance) and sequences one
// 128-bit block at a time through it:
//   - It accepts a plaintext block on a valid/ready handshake and applies the
//     initial AddRoundKey with round key 0.
//   - It runs NR-1 full rounds and one final round. Each round waits out the
//     ROUND_LAT-cycle registered latency of the datapath.
//   - It presents the ciphertext on a valid/ready output handshake.
//
// Parameters
//   ROUND_LAT  datapath latency in cycles, 1..15
//   NR         number of AES rounds: 10, 12 or 14
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   plaintext handshake; in_ready is high only in IDLE
//   in_data             plaintext block
//   out_valid/out_ready ciphertext handshake; out_valid is high only in DONE
//   out_data            ciphertext (the working state register)
//   rk_idx, rk_in       round-key index to the key store, and the key it
//                       returns combinationally
//   rnd_din, rnd_key    state and key driven into the shared datapath
//   final_sel           high during round NR; selects fin_dout
//   rnd_dout, fin_dout  outputs of the full-round and final-round instances
//   busy                high while a block is in flight or waiting for output
//   blk_cnt             completed-block counter. It exists only when the
//                       AES_SEQ_PERF_EN macro is defined.
//
// Optional feature macro: AES_SEQ_PERF_EN
// -----------------------------------------------------------------------------
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a plaintext block; rnd_q = 0 so key 0 is presented
// ROUND | round rnd_q in flight; wcnt_q counts datapath latency cycles
// DONE  | ciphertext held on out_data until out_ready

module aes_round_sequencer #(
  parameter int ROUND_LAT = 3,
  parameter int NR        = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  output logic [127:0] rnd_din,
  output logic [127:0] rnd_key,
  output logic         final_sel,
  input  logic [127:0] rnd_dout,
  input  logic [127:0] fin_dout,
  output logic         busy
`ifdef AES_SEQ_PERF_EN
  ,
  output logic [15:0]  blk_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } st_e;

  localparam logic [3:0] LAT_C = 4'(ROUND_LAT);
  localparam logic [3:0] NR_C  = 4'(NR);

  st_e          st_q, st_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [3:0]   wcnt_q, wcnt_d;

  // The datapath inputs come straight from registers. They are stable for the
  // whole round, which is what a registered datapath of fixed latency needs.
  assign rk_idx    = rnd_q;
  assign rnd_din   = state_q;
  assign rnd_key   = rk_in;
  assign out_data  = state_q;
  assign final_sel = (st_q == ROUND) && (rnd_q == NR_C);

  always_comb begin
    st_d      = st_q;
    state_d   = state_q;
    rnd_d     = rnd_q;
    wcnt_d    = wcnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (st_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // rk_idx is 0 in IDLE, so rk_in is the initial round key here.
          state_d = in_data ^ rk_in;
          rnd_d   = 4'd1;
          wcnt_d  = 4'd0;
          st_d    = ROUND;
        end
      end
      ROUND: begin
        busy = 1'b1;
        if (wcnt_q == LAT_C) begin
          state_d = final_sel ? fin_dout : rnd_dout;
          wcnt_d  = 4'd0;
          if (rnd_q == NR_C) begin
            st_d = DONE;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          st_d  = IDLE;
          rnd_d = 4'd0;
        end
      end
      default: begin
        st_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
      wcnt_q  <= wcnt_d;
    end
  end

`ifdef AES_SEQ_PERF_EN
  logic [15:0] blk_cnt_q;

  // The counter wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aes_round_sequencer
//
// Directed bench for aes_round_sequencer. It contains a behavioural AES-128
// key store and three sequencer instances:
//   - main:  ROUND_LAT=3, NR=10, driven by a pipelined AES round model
//   - dut_a: ROUND_LAT=1, NR=10, driven by a one-stage AES round model
//   - dut_b: ROUND_LAT=15, NR=14, driven by a simple xor datapath. With that
//            datapath the result is ~(pt ^ k0 ^ ... ^ k14).
// -----------------------------------------------------------------------------
module tb_aes_round_sequencer;

  localparam int L0 = 3;

  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int tests = 0;
  int fails = 0;

  logic [127:0] rk_tab [16];

  // ---------------------------------------------------------------- AES model
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box as inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] b = x;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, b);
      b = gmul(b, b);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o = '0;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k);
    return mix(sub_shift(s)) ^ k;
  endfunction

  function automatic logic [127:0] aes_final(input logic [127:0] s, input logic [127:0] k);
    return sub_shift(s) ^ k;
  endfunction

  task automatic set_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]) ^ rcon, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_tab[r] = (r < 11) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // ---------------------------------------------------------------- main DUT
  logic         in_valid, in_ready, out_valid, out_ready, final_sel, busy;
  logic [127:0] in_data, out_data, rk_in, rnd_din, rnd_key, rnd_dout, fin_dout;
  logic [3:0]   rk_idx;
`ifdef AES_SEQ_PERF_EN
  logic [15:0]  blk_cnt, blk_cnt_a, blk_cnt_b;
`endif
  logic [127:0] p_rnd [L0];
  logic [127:0] p_fin [L0];

  assign rk_in = rk_tab[rk_idx];

  always_ff @(posedge clk) begin
    p_rnd[0] <= aes_round(rnd_din, rnd_key);
    p_fin[0] <= aes_final(rnd_din, rnd_key);
    for (int i = 1; i < L0; i++) begin
      p_rnd[i] <= p_rnd[i-1];
      p_fin[i] <= p_fin[i-1];
    end
  end
  assign rnd_dout = p_rnd[L0-1];
  assign fin_dout = p_fin[L0-1];

  aes_round_sequencer #(.ROUND_LAT(L0), .NR(10)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rk_idx(rk_idx), .rk_in(rk_in), .rnd_din(rnd_din), .rnd_key(rnd_key),
    .final_sel(final_sel), .rnd_dout(rnd_dout), .fin_dout(fin_dout),
    .busy(busy)
`ifdef AES_SEQ_PERF_EN
    , .blk_cnt(blk_cnt)
`endif
  );

  // ---------------------------------------------------------------- dut_a
  logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a, final_sel_a, busy_a;
  logic [127:0] out_data_a, rk_in_a, rnd_din_a, rnd_key_a, rnd_dout_a, fin_dout_a;
  logic [3:0]   rk_idx_a;

  assign rk_in_a = rk_tab[rk_idx_a];
  always_ff @(posedge clk) begin
    rnd_dout_a <= aes_round(rnd_din_a, rnd_key_a);
    fin_dout_a <= aes_final(rnd_din_a, rnd_key_a);
  end

  aes_round_sequencer #(.ROUND_LAT(1), .NR(10)) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .rk_idx(rk_idx_a), .rk_in(rk_in_a), .rnd_din(rnd_din_a), .rnd_key(rnd_key_a),
    .final_sel(final_sel_a), .rnd_dout(rnd_dout_a), .fin_dout(fin_dout_a),
    .busy(busy_a)
`ifdef AES_SEQ_PERF_EN
    , .blk_cnt(blk_cnt_a)
`endif
  );

  // ---------------------------------------------------------------- dut_b
  logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, final_sel_b, busy_b;
  logic [127:0] out_data_b, rk_in_b, rnd_din_b, rnd_key_b, rnd_dout_b, fin_dout_b;
  logic [3:0]   rk_idx_b;

  assign rk_in_b    = rk_tab[rk_idx_b];
  assign rnd_dout_b = rnd_din_b ^ rnd_key_b;
  assign fin_dout_b = ~(rnd_din_b ^ rnd_key_b);

  aes_round_sequencer #(.ROUND_LAT(15), .NR(14)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .rk_idx(rk_idx_b), .rk_in(rk_in_b), .rnd_din(rnd_din_b), .rnd_key(rnd_key_b),
    .final_sel(final_sel_b), .rnd_dout(rnd_dout_b), .fin_dout(fin_dout_b),
    .busy(busy_b)
`ifdef AES_SEQ_PERF_EN
    , .blk_cnt(blk_cnt_b)
`endif
  );

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one accept edge on the main DUT. On return we are just after it.
  task automatic accept_main(input logic [127:0] pt);
    in_data  = pt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge until out_valid, with a cycle budget.
  task automatic wait_main(output int n);
    n = 0;
    while (!out_valid && n < 600) begin
      tick();
      n++;
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = PT1;
    tick(); tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tests++;
    if ({in_ready, out_valid, busy, final_sel} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 1000", {in_ready, out_valid, busy, final_sel});
    end
    tests++;
    if (out_data !== 128'h0 || rk_idx !== 4'd0) begin
      fails++;
      $display("FAIL reset_data: out_data %h rk_idx %0d expected 0 and 0", out_data, rk_idx);
    end
`ifdef AES_SEQ_PERF_EN
    tests++;
    if (blk_cnt !== 16'h0) begin
      fails++;
      $display("FAIL reset_blk_cnt: got %h expected 0000", blk_cnt);
    end
`endif
  endtask

  task automatic test_fips_c1();
    int n;
    int exp_idx;
    set_key(K1);
    accept_main(PT1);
    n = 0;
    while (!out_valid && n < 600) begin
      if (n < 40) begin
        exp_idx = n / (L0 + 1) + 1;
        tests++;
        if (rk_idx !== 4'(exp_idx) || final_sel !== (exp_idx == 10) || busy !== 1'b1) begin
          fails++;
          $display("FAIL c1_round_seq: cycle %0d rk_idx %0d final_sel %b busy %b expected %0d %b 1",
                   n, rk_idx, final_sel, busy, exp_idx, (exp_idx == 10));
        end
      end
      tick();
      n++;
    end
    tests++;
    if (n !== 40) begin
      fails++;
      $display("FAIL c1_latency: got %0d expected 40", n);
    end
    tests++;
    if (out_data !== CT1) begin
      fails++;
      $display("FAIL c1_ciphertext: got %h expected %h", out_data, CT1);
    end
    tests++;
    if (final_sel !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL c1_done_flags: final_sel %b in_ready %b expected 0 0", final_sel, in_ready);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++;
    if ({in_ready, out_valid, busy} !== 3'b100 || rk_idx !== 4'd0) begin
      fails++;
      $display("FAIL c1_after_out: in_ready/out_valid/busy %b rk_idx %0d expected 100 0",
               {in_ready, out_valid, busy}, rk_idx);
    end
  endtask

  task automatic test_backpressure();
    int n;
    accept_main(PT1);
    wait_main(n);
    in_valid = 1'b1;
    in_data  = PT2;
    for (int i = 0; i < 20; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_data !== CT1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold: cycle %0d out_valid %b in_ready %b out_data %h expected 1 0 %h",
                 i, out_valid, in_ready, out_data, CT1);
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      fails++;
      $display("FAIL bp_release: in_ready/busy/out_valid %b expected 100", {in_ready, busy, out_valid});
    end
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b1;
    accept_main(PT1);
    wait_main(n);
    tests++;
    if (n !== 40 || out_data !== CT1) begin
      fails++;
      $display("FAIL b2b_first: latency %0d data %h expected 40 %h", n, out_data, CT1);
    end
    // Offer the next block while the first is still in DONE; it must not
    // be taken on the output handshake edge.
    set_key(K2);
    in_data  = PT2;
    in_valid = 1'b1;
    tick();
    tests++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      fails++;
      $display("FAIL b2b_gap: in_ready/out_valid/busy %b expected 100", {in_ready, out_valid, busy});
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if ({in_ready, busy} !== 2'b01) begin
      fails++;
      $display("FAIL b2b_accept: in_ready/busy %b expected 01", {in_ready, busy});
    end
    wait_main(n);
    tests++;
    if (n !== 40 || out_data !== CT2) begin
      fails++;
      $display("FAIL b2b_second: latency %0d data %h expected 40 %h", n, out_data, CT2);
    end
    tick();
    out_ready = 1'b0;
    set_key(K1);
  endtask

  task automatic test_reset_mid_round();
    int n;
    // Reset in the same cycle as an offered block: nothing is accepted.
    in_data  = PT1;
    in_valid = 1'b1;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    tests++;
    if ({in_ready, busy} !== 2'b10) begin
      fails++;
      $display("FAIL rst_with_accept: in_ready/busy %b expected 10", {in_ready, busy});
    end
    accept_main(PT2);
    n = 0;
    while (rk_idx !== 4'd5 && n < 100) begin
      tick();
      n++;
    end
    tests++;
    if (rk_idx !== 4'd5) begin
      fails++;
      $display("FAIL rst_reach_round5: rk_idx %0d expected 5", rk_idx);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if ({in_ready, out_valid, busy} !== 3'b100 || rk_idx !== 4'd0 || out_data !== 128'h0) begin
      fails++;
      $display("FAIL rst_mid_round: in_ready/out_valid/busy %b rk_idx %0d out_data %h expected 100 0 0",
               {in_ready, out_valid, busy}, rk_idx, out_data);
    end
    accept_main(PT1);
    wait_main(n);
    tests++;
    if (n !== 40 || out_data !== CT1) begin
      fails++;
      $display("FAIL rst_next_block: latency %0d data %h expected 40 %h", n, out_data, CT1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_latency_sweep();
    int n;
    logic [127:0] kx;
    // ROUND_LAT=1, NR=10 with the real AES round model.
    in_data    = PT1;
    in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    n = 0;
    while (!out_valid_a && n < 100) begin
      tick();
      n++;
    end
    tests++;
    if (n !== 20 || out_data_a !== CT1) begin
      fails++;
      $display("FAIL lat1_nr10: latency %0d data %h expected 20 %h", n, out_data_a, CT1);
    end
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;
    tests++;
    if ({in_ready_a, busy_a, final_sel_a} !== 3'b100) begin
      fails++;
      $display("FAIL lat1_after_out: in_ready/busy/final_sel %b expected 100",
               {in_ready_a, busy_a, final_sel_a});
    end

    // ROUND_LAT=15, NR=14 with the xor datapath.
    kx = '0;
    for (int r = 0; r < 15; r++) kx = kx ^ rk_tab[r];
    in_data    = PT2;
    in_valid_b = 1'b1;
    tick();
    in_valid_b = 1'b0;
    n = 0;
    while (!out_valid_b && n < 400) begin
      tests++;
      if (final_sel_b !== (rk_idx_b == 4'd14)) begin
        fails++;
        $display("FAIL lat15_final_sel: cycle %0d rk_idx %0d final_sel %b", n, rk_idx_b, final_sel_b);
      end
      tick();
      n++;
    end
    tests++;
    if (n !== 224 || out_data_b !== ~(PT2 ^ kx)) begin
      fails++;
      $display("FAIL lat15_nr14: latency %0d data %h expected 224 %h", n, out_data_b, ~(PT2 ^ kx));
    end
    out_ready_b = 1'b1;
    tick();
    out_ready_b = 1'b0;
  endtask

`ifdef AES_SEQ_PERF_EN
  task automatic test_counter_wrap();
    int n;
    // One handshake since the last reset (the block after the mid-round reset).
    tests++;
    if (blk_cnt !== 16'd1) begin
      fails++;
      $display("FAIL cnt_value: got %h expected 0001", blk_cnt);
    end
    force dut.blk_cnt_q = 16'hffff;
    #1;
    release dut.blk_cnt_q;
    #1;
    tests++;
    if (blk_cnt !== 16'hffff) begin
      fails++;
      $display("FAIL cnt_forced: got %h expected ffff", blk_cnt);
    end
    accept_main(PT1);
    wait_main(n);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++;
    if (blk_cnt !== 16'h0000) begin
      fails++;
      $display("FAIL cnt_wrap: got %h expected 0000", blk_cnt);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
    out_ready = 1'b0; out_ready_a = 1'b0; out_ready_b = 1'b0;
    in_data = '0;
    set_key(K1);
    #1;
    test_reset();
    test_fips_c1();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_round();
    test_latency_sweep();
`ifdef AES_SEQ_PERF_EN
    test_counter_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
